frac_lutk_cfg: RTL and testbench

//  Parametrised fracturable K-input LUT with its own configuration chain.
//  - Config is loaded serially into a shadow register, parity-checked, then committed atomically to the active config.
//  - Active config drives a K-input mux tree with fracture taps, plus an optional registered full-LUT output.
//  - One instance per logic-element LUT slot. Tiles daisy-chain cfg_din/cfg_dout.

---
 rtl/frac_lut_pkg.sv | 31 +++
 rtl/frac_lut_tree.sv | 33 +++
 rtl/frac_lutk_cfg.sv | 113 +++++++++++
 tb/tb_frac_lutk_cfg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/frac_lut_pkg.sv
// Shared field layout and tap indexing for the fracturable LUT and its config chain.
package frac_lut_pkg;

    localparam int unsigned TT_LSB = 0;

    function automatic int unsigned n_cfg(input int unsigned k, input int unsigned frac);
        return (32'd1 << k) + frac + 32'd2;
    endfunction

    function automatic int unsigned mode_lsb(input int unsigned k);
        return 32'd1 << k;
    endfunction

    function automatic int unsigned regsel_bit(input int unsigned k, input int unsigned frac);
        return (32'd1 << k) + frac;
    endfunction

    function automatic int unsigned par_bit(input int unsigned k, input int unsigned frac);
        return (32'd1 << k) + frac + 32'd1;
    endfunction

    function automatic int unsigned tap_w(input int unsigned frac);
        return (32'd1 << (frac + 32'd1)) - 32'd2;
    endfunction

    // Level l occupies 2^l tap bits starting at 2^l-2 (level 1 at the LSBs).
    function automatic int unsigned tap_idx(input int unsigned lvl, input int unsigned idx);
        return (32'd1 << lvl) - 32'd2 + idx;
    endfunction

endpackage

// File: rtl/frac_lut_tree.sv
// Combinational K-level 2:1 mux tree; stage s resolves address bit s-1 and exports fracture taps.
module frac_lut_tree
    import frac_lut_pkg::*;
#(
    parameter int unsigned K    = 6,
    parameter int unsigned FRAC = 2
) (
    input  logic [(2**K)-1:0]        tt_i,
    input  logic [K-1:0]             addr_i,
    output logic                     full_o,
    output logic [tap_w(FRAC)-1:0]   tap_o
);

    for (genvar s = 0; s <= K; s++) begin : g_lvl
        localparam int unsigned W = 2 ** (K - s);
        logic [W-1:0] v;
        if (s == 0) begin : g_leaf
            assign v = tt_i;
        end else begin : g_mux
            for (genvar i = 0; i < W; i++) begin : g_node
                assign v[i] = addr_i[s-1] ? g_lvl[s-1].v[2*i+1] : g_lvl[s-1].v[2*i];
            end
        end
    end

    assign full_o = g_lvl[K].v[0];

    // Stage K-l holds 2^l nodes, node i = tt[i*2^(K-l) + a[K-l-1:0]].
    for (genvar l = 1; l <= FRAC; l++) begin : g_tap
        assign tap_o[tap_idx(l, 0) +: (2 ** l)] = g_lvl[K-l].v;
    end

endmodule

// File: rtl/frac_lutk_cfg.sv
// Fracturable K-input LUT with serial shadow config, parity-checked atomic commit and optional output register.
module frac_lutk_cfg
    import frac_lut_pkg::*;
#(
    parameter int unsigned K    = 6,
    parameter int unsigned FRAC = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_en,
    input  logic                     cfg_din,
    output logic                     cfg_dout,
    input  logic                     cfg_commit,
    output logic                     cfg_done,
    output logic                     cfg_err,
    input  logic [K-1:0]             in,
    input  logic                     ff_en,
    output logic                     lut_k_out,
    output logic [tap_w(FRAC)-1:0]   lut_tap_out
);

    localparam int unsigned N_CFG      = n_cfg(K, FRAC);
    localparam int unsigned NT         = 2 ** K;
    localparam int unsigned MODE_LSB   = mode_lsb(K);
    localparam int unsigned REGSEL_BIT = regsel_bit(K, FRAC);
    localparam int unsigned PAR_BIT    = par_bit(K, FRAC);
    localparam int unsigned CNT_W      = $clog2(N_CFG + 1);

    logic [N_CFG-1:0]   shadow_q, shadow_d;
    // Parity is only meaningful in the shadow, so active stops below it.
    logic [PAR_BIT-1:0] active_q, active_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ff_q, ff_d;
    logic               commit_ok_c;
    logic               full_c;
    logic [K-1:0]       eff_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ff_q     <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
        end
    end

    assign commit_ok_c = cfg_commit && !cfg_en && (cnt_q == CNT_W'(N_CFG)) && !(^shadow_q);

    // Shift/commit next-state; a simultaneous shift always wins and the commit is rejected.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        err_d    = err_q;
        if (cfg_en) begin
            shadow_d = {shadow_q[N_CFG-2:0], cfg_din};
            cnt_d    = (cnt_q == CNT_W'(N_CFG)) ? cnt_q : cnt_q + CNT_W'(1);
            done_d   = 1'b0;
        end
        if (cfg_commit) begin
            cnt_d = '0;
            if (commit_ok_c) begin
                active_d = shadow_q[PAR_BIT-1:0];
                done_d   = 1'b1;
                err_d    = 1'b0;
            end else begin
                done_d = 1'b0;
                err_d  = 1'b1;
            end
        end
    end

    // Mode bit j pins input K-1-j high, splitting the table into smaller LUTs.
    always_comb begin
        eff_c = in;
        for (int j = 0; j < int'(FRAC); j++) begin
            if (active_q[MODE_LSB + j]) eff_c[K-1-j] = 1'b1;
        end
    end

    frac_lut_tree #(
        .K    (K),
        .FRAC (FRAC)
    ) u_tree (
        .tt_i   (active_q[TT_LSB +: NT]),
        .addr_i (eff_c),
        .full_o (full_c),
        .tap_o  (lut_tap_out)
    );

    always_comb begin
        ff_d = ff_q;
        if (ff_en) ff_d = full_c;
    end

    assign cfg_dout  = shadow_q[N_CFG-1];
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign lut_k_out = active_q[REGSEL_BIT] ? ff_q : full_c;

endmodule

// File: tb/tb_frac_lutk_cfg.sv
// Directed self-checking bench for frac_lutk_cfg at K=4, FRAC=2 (20-bit chain).
module tb_frac_lutk_cfg;

    localparam int unsigned K     = 4;
    localparam int unsigned FRAC  = 2;
    localparam int unsigned N     = 20;
    localparam int unsigned TAP_W = 6;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cfg_en;
    logic             cfg_din;
    logic             cfg_dout;
    logic             cfg_commit;
    logic             cfg_done;
    logic             cfg_err;
    logic [K-1:0]     lut_in;
    logic             ff_en;
    logic             lut_k_out;
    logic [TAP_W-1:0] lut_tap_out;

    int n_cmp = 0;
    int n_bad = 0;

    frac_lutk_cfg #(
        .K    (K),
        .FRAC (FRAC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_en      (cfg_en),
        .cfg_din     (cfg_din),
        .cfg_dout    (cfg_dout),
        .cfg_commit  (cfg_commit),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .in          (lut_in),
        .ff_en       (ff_en),
        .lut_k_out   (lut_k_out),
        .lut_tap_out (lut_tap_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Config word {parity, reg_sel, mode, tt} with even overall parity.
    function automatic logic [N-1:0] mk_word(input logic [15:0] tt, input logic [1:0] m, input logic rs);
        logic [N-2:0] body;
        body = {rs, m, tt};
        return {^body, body};
    endfunction

    // Shift the top nbits of w, MSB first, so a full load lands bit N-1 at shadow[N-1].
    task automatic load(input logic [N-1:0] w, input int nbits);
        for (int i = N - 1; i >= int'(N) - nbits; i--) begin
            cfg_din = w[i];
            cfg_en  = 1'b1;
            tick();
        end
        cfg_en  = 1'b0;
        cfg_din = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    logic [N-1:0] and4_w, fx_w, and4r_w, bad_w;
    logic         bits [40];

    initial begin
        reset_n    = 1'b0;
        cfg_en     = 1'b0;
        cfg_din    = 1'b0;
        cfg_commit = 1'b0;
        lut_in     = 4'hF;
        ff_en      = 1'b0;
        and4_w     = mk_word(16'h8000, 2'b00, 1'b0);
        fx_w       = mk_word(16'hF00F, 2'b01, 1'b0);
        and4r_w    = mk_word(16'h8000, 2'b00, 1'b1);
        bad_w      = and4_w ^ 20'h80000;

        // Reset state
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_lut", 32'(lut_k_out), 32'd0);
        check("rst_taps", 32'(lut_tap_out), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_dout", 32'(cfg_dout), 32'd0);

        // AND4 load
        check("and4_par", 32'(and4_w[19]), 32'd1);
        load(and4_w, 20);
        commit();
        check("and4_done", 32'(cfg_done), 32'd1);
        check("and4_err", 32'(cfg_err), 32'd0);
        lut_in = 4'hF; #1;
        check("and4_F", 32'(lut_k_out), 32'd1);
        lut_in = 4'h7; #1;
        check("and4_7", 32'(lut_k_out), 32'd0);

        // Rejected commits
        load(and4_w, 19);
        commit();
        check("short_err", 32'(cfg_err), 32'd1);
        check("short_done", 32'(cfg_done), 32'd0);
        lut_in = 4'hF; #1;
        check("short_keep", 32'(lut_k_out), 32'd1);
        load(and4_w, 20);
        commit();
        check("reload_err", 32'(cfg_err), 32'd0);
        load(bad_w, 20);
        commit();
        check("par_err", 32'(cfg_err), 32'd1);
        check("par_keep", 32'(lut_k_out), 32'd1);
        load(and4_w, 20);
        commit();
        check("ok_done", 32'(cfg_done), 32'd1);
        cfg_en     = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_en     = 1'b0;
        cfg_commit = 1'b0;
        check("both_err", 32'(cfg_err), 32'd1);
        check("both_done", 32'(cfg_done), 32'd0);

        // Fractured mode: tt=F00F, in[3] forced high
        load(fx_w, 20);
        commit();
        check("frac_done", 32'(cfg_done), 32'd1);
        lut_in = 4'h0; #1;
        check("frac_tap_0", 32'(lut_tap_out), 32'h25);
        check("frac_lut_0", 32'(lut_k_out), 32'd0);
        lut_in = 4'h7; #1;
        check("frac_tap_7", 32'(lut_tap_out), 32'h26);
        check("frac_lut_7", 32'(lut_k_out), 32'd1);
        lut_in = 4'hF; #1;
        check("frac_tap_F", 32'(lut_tap_out), 32'h26);
        lut_in = 4'h3; #1;
        check("frac_tap_3", 32'(lut_tap_out), 32'h25);
        lut_in = 4'hB; #1;
        check("frac_tap_B", 32'(lut_tap_out), 32'h25);
        check("frac_lut_B", 32'(lut_k_out), 32'd0);

        // Registered output
        load(and4r_w, 20);
        commit();
        lut_in = 4'h0;
        ff_en  = 1'b1;
        tick();
        check("reg_lo", 32'(lut_k_out), 32'd0);
        lut_in = 4'hF; #1;
        check("reg_lat", 32'(lut_k_out), 32'd0);
        tick();
        check("reg_hi", 32'(lut_k_out), 32'd1);
        ff_en  = 1'b0;
        lut_in = 4'h0;
        tick();
        tick();
        check("reg_hold", 32'(lut_k_out), 32'd1);

        // Chain pass-through
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int s = 1; s <= 40; s++) begin
            bits[s-1] = 1'($urandom_range(0, 1));
            cfg_din   = bits[s-1];
            cfg_en    = 1'b1;
            tick();
            check($sformatf("chain_%0d", s), 32'(cfg_dout), (s >= 20) ? 32'(bits[s-20]) : 32'd0);
        end
        cfg_din = 1'b1;
        for (int s = 0; s < 5; s++) tick();
        reset_n = 1'b0;
        tick();
        check("midrst_dout", 32'(cfg_dout), 32'd0);
        reset_n = 1'b1;
        cfg_en  = 1'b0;
        lut_in  = 4'hF; #1;
        check("midrst_lut", 32'(lut_k_out), 32'd0);
        load(and4_w, 19);
        commit();
        check("midrst_cnt", 32'(cfg_err), 32'd1);
        load(and4_w, 20);
        commit();
        check("post_done", 32'(cfg_done), 32'd1);
        check("post_lut", 32'(lut_k_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
